// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: width defaults, CPU handshake states, access owner tags.
package vram_arbiter_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FLIGHT,
    DONE
  } cpu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_t;

endpackage

// File: rtl/vram_arbiter_pipe.sv
// Issue/return pipeline: registers the RAM strobe, tracks the owner until data returns, routes read data.
// Fixed latency: issue edge -> ram_* next cycle -> ram_rdata -> registered owner result; no backpressure.
module vram_arbiter_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  owner_t            issue_own,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_wdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata
);

  owner_t own_s1;
  owner_t own_s2;
  logic   we_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      own_s1    <= OWN_NONE;
      own_s2    <= OWN_NONE;
      we_s2     <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_valid <= 1'b0;
      vid_rdata <= '0;
    end else begin
      ram_ce <= (issue_own != OWN_NONE);
      ram_we <= (issue_own == OWN_CPU) && issue_we;
      if (issue_own != OWN_NONE) begin
        ram_addr  <= issue_addr;
        ram_wdata <= issue_wdata;
      end
      // own_s1 is aligned with ram_ce, own_s2 with the cycle ram_rdata is valid
      own_s1    <= issue_own;
      own_s2    <= own_s1;
      we_s2     <= ram_we;
      cpu_ack   <= (own_s2 == OWN_CPU);
      vid_valid <= (own_s2 == OWN_VID);
      if (own_s2 == OWN_CPU && !we_s2) cpu_rdata <= ram_rdata;
      if (own_s2 == OWN_VID) vid_rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between a Z80-style CPU (level req, WAIT) and a video fetcher; 3-cycle result latency.
// Video has priority; `define VRAM_ARBITER_STARVE_GUARD_EN forces a CPU slot after STARVE_MAX video grants.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  cpu_state_t        state;
  cpu_state_t        state_nxt;
  logic              force_cpu;
  logic              cpu_accept;
  logic              vid_accept;
  owner_t            issue_own;
  logic [ADDR_W-1:0] issue_addr;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_cpu = (state == PEND) && (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state_nxt != PEND || cpu_accept) begin
      starve_cnt <= '0;
    end else if (state == PEND && vid_accept && starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  // The starve limit only shapes the guard; it is kept referenced in this build.
  logic unused_starve;
  assign unused_starve = (STARVE_MAX > 0);
  assign force_cpu     = 1'b0;
`endif

  assign vid_gnt    = reset || !force_cpu;
  assign vid_accept = vid_req && vid_gnt;
  assign cpu_accept = (state == PEND) && cpu_req && (!vid_req || force_cpu);

  // WAIT releases in the ack cycle itself so the Z80 samples data in the same T-state
  assign cpu_wait_n = reset ||
                      !(cpu_req && (state != DONE) && !(state == FLIGHT && cpu_ack));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = PEND;
      PEND: begin
        if (!cpu_req)        state_nxt = IDLE;
        else if (cpu_accept) state_nxt = FLIGHT;
      end
      FLIGHT:  if (cpu_ack) state_nxt = cpu_req ? DONE : IDLE;
      DONE:    if (!cpu_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_own  = OWN_NONE;
    issue_addr = vid_addr;
    if (cpu_accept) begin
      issue_own  = OWN_CPU;
      issue_addr = cpu_addr;
    end else if (vid_accept) begin
      issue_own  = OWN_VID;
    end
  end

  vram_arbiter_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_own   (issue_own),
    .issue_we    (cpu_we),
    .issue_addr  (issue_addr),
    .issue_wdata (cpu_wdata),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .vid_valid   (vid_valid),
    .vid_rdata   (vid_rdata)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous RAM model; covers both starve-guard builds.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_pass  = 0;
  int n_total = 0;

  vram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rdata  (vid_rdata),
    .vid_valid  (vid_valid),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after ram_ce
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vid_req   = 1'b0;
    vid_addr  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    cpu_req = 1'b1;
    tick();
    tick();
    n_total++;
    if ({ram_ce, ram_we, cpu_ack, vid_valid} !== 4'b0000)
      $display("FAIL rst_strobes: got %b want 0000", {ram_ce, ram_we, cpu_ack, vid_valid});
    else n_pass++;
    n_total++;
    if ({cpu_wait_n, vid_gnt} !== 2'b11)
      $display("FAIL rst_wait_gnt: got %b want 11", {cpu_wait_n, vid_gnt});
    else n_pass++;
    n_total++;
    if ({ram_addr, ram_wdata, cpu_rdata, vid_rdata} !== '0)
      $display("FAIL rst_data: addr %h wdata %h cpu_rdata %h vid_rdata %h want all 0",
               ram_addr, ram_wdata, cpu_rdata, vid_rdata);
    else n_pass++;
    cpu_req = 1'b0;
    reset   = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read;
    mem[13'h0123] <= 8'hA5;
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0123;
    #1;
    n_total++;
    if (cpu_wait_n !== 1'b0) $display("FAIL rd_wait_idle: got %b want 0", cpu_wait_n);
    else n_pass++;
    tick();
    n_total++;
    if ({ram_ce, cpu_wait_n} !== 2'b00) $display("FAIL rd_pend: ce/wait %b want 00", {ram_ce, cpu_wait_n});
    else n_pass++;
    tick();
    n_total++;
    if ({ram_ce, ram_we, ram_addr, cpu_wait_n} !== {1'b1, 1'b0, 13'h0123, 1'b0})
      $display("FAIL rd_issue: ce %b we %b addr %h wait %b want 1 0 0123 0", ram_ce, ram_we, ram_addr, cpu_wait_n);
    else n_pass++;
    tick();
    n_total++;
    if ({cpu_ack, cpu_wait_n} !== 2'b00) $display("FAIL rd_mid: ack/wait %b want 00", {cpu_ack, cpu_wait_n});
    else n_pass++;
    tick();
    n_total++;
    if ({cpu_ack, cpu_rdata, cpu_wait_n} !== {1'b1, 8'hA5, 1'b1})
      $display("FAIL rd_ack: ack %b rdata %h wait %b want 1 a5 1", cpu_ack, cpu_rdata, cpu_wait_n);
    else n_pass++;
    tick();
    n_total++;
    if ({cpu_ack, cpu_wait_n} !== 2'b01) $display("FAIL rd_done: ack/wait %b want 01", {cpu_ack, cpu_wait_n});
    else n_pass++;
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_vid_burst;
    int nv    = 0;
    int first = -1;
    int last  = -1;
    int bad_gnt = 0;
    for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h30 + i);
    tick();
    for (int c = 0; c < 14; c++) begin
      vid_req  = (c < 8);
      vid_addr = AW'(c);
      #1;
      if (c < 8 && vid_gnt !== 1'b1) bad_gnt++;
      tick();
      if (vid_valid === 1'b1) begin
        n_total++;
        if (vid_rdata !== 8'(8'h30 + nv))
          $display("FAIL vid_data%0d: got %h want %h", nv, vid_rdata, 8'(8'h30 + nv));
        else n_pass++;
        if (first < 0) first = c + 1;
        last = c + 1;
        nv++;
      end
    end
    vid_req = 1'b0;
    n_total++;
    if (nv != 8) $display("FAIL vid_count: got %0d want 8", nv);
    else n_pass++;
    n_total++;
    if (first != 3 || last != 10) $display("FAIL vid_window: first %0d last %0d want 3 10", first, last);
    else n_pass++;
    n_total++;
    if (bad_gnt != 0) $display("FAIL vid_gnt: %0d cycles without grant, want 0", bad_gnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_starve;
    mem[13'h1FFF] <= 8'h00;
    idle_inputs();
    tick();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h1FFF;
    cpu_wdata = 8'h5A;
`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    begin
      int nacc = 0;
      int gnt0_cycle = -1;
      int n_gnt0 = 0;
      int ack_cycle = -1;
      for (int c = 0; c < 20; c++) begin
        vid_req  = 1'b1;
        vid_addr = AW'(13'h100 + c);
        #1;
        if (c >= 1 && gnt0_cycle < 0 && vid_gnt === 1'b1) nacc++;
        if (vid_gnt !== 1'b1) begin
          n_gnt0++;
          if (gnt0_cycle < 0) gnt0_cycle = c;
        end
        tick();
        if (cpu_ack === 1'b1 && ack_cycle < 0) ack_cycle = c + 1;
      end
      n_total++;
      if (nacc != 4) $display("FAIL starve_vid_accepts: got %0d want 4", nacc);
      else n_pass++;
      n_total++;
      if (gnt0_cycle != 5 || n_gnt0 != 1)
        $display("FAIL starve_gnt: first low %0d count %0d want 5 1", gnt0_cycle, n_gnt0);
      else n_pass++;
      n_total++;
      if (ack_cycle != 8) $display("FAIL starve_ack: cycle %0d want 8", ack_cycle);
      else n_pass++;
    end
`else
    begin
      int bad = 0;
      int n_ack = 0;
      int n_we = 0;
      int ack_k = -1;
      for (int c = 0; c < 10; c++) begin
        vid_req  = 1'b1;
        vid_addr = AW'(13'h100 + c);
        #1;
        if (cpu_wait_n !== 1'b0 || vid_gnt !== 1'b1) bad++;
        tick();
        if (cpu_ack === 1'b1) n_ack++;
        if (ram_we === 1'b1) n_we++;
      end
      n_total++;
      if (bad != 0) $display("FAIL prio_wait_gnt: %0d bad cycles want 0", bad);
      else n_pass++;
      n_total++;
      if (n_ack != 0 || n_we != 0) $display("FAIL prio_cpu_blocked: acks %0d writes %0d want 0 0", n_ack, n_we);
      else n_pass++;
      vid_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (cpu_ack === 1'b1 && ack_k < 0) ack_k = k;
      end
      n_total++;
      if (ack_k != 2) $display("FAIL prio_release_ack: tick %0d want 2", ack_k);
      else n_pass++;
    end
`endif
    n_total++;
    if (mem[13'h1FFF] !== 8'h5A) $display("FAIL starve_write: ram %h want 5a", mem[13'h1FFF]);
    else n_pass++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_held_req;
    int n_ce = 0;
    int n_ack = 0;
    mem[13'h0456] <= 8'h3C;
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0456;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (ram_ce === 1'b1) n_ce++;
      if (cpu_ack === 1'b1) n_ack++;
    end
    n_total++;
    if (n_ce != 1 || n_ack != 1) $display("FAIL held_single: accesses %0d acks %0d want 1 1", n_ce, n_ack);
    else n_pass++;
    n_total++;
    if ({cpu_rdata, cpu_wait_n} !== {8'h3C, 1'b1})
      $display("FAIL held_done: rdata %h wait %b want 3c 1", cpu_rdata, cpu_wait_n);
    else n_pass++;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int n_ack = 0;
    int n_val = 0;
    mem[13'h0789] <= 8'hC3;
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0789;
    tick();
    tick();
    n_total++;
    if (ram_ce !== 1'b1) $display("FAIL rmid_issue: ce %b want 1", ram_ce);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if ({ram_ce, ram_we, cpu_ack, vid_valid, cpu_wait_n, vid_gnt} !== 6'b000011)
      $display("FAIL rmid_ctrl: got %b want 000011", {ram_ce, ram_we, cpu_ack, vid_valid, cpu_wait_n, vid_gnt});
    else n_pass++;
    n_total++;
    if ({ram_addr, ram_wdata, cpu_rdata, vid_rdata} !== '0)
      $display("FAIL rmid_data: addr %h wdata %h cpu_rdata %h vid_rdata %h want all 0",
               ram_addr, ram_wdata, cpu_rdata, vid_rdata);
    else n_pass++;
    tick();
    cpu_req = 1'b0;
    reset   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cpu_ack === 1'b1) n_ack++;
      if (vid_valid === 1'b1) n_val++;
    end
    n_total++;
    if (n_ack != 0 || n_val != 0 || cpu_rdata !== 8'h00)
      $display("FAIL rmid_discard: acks %0d valids %0d rdata %h want 0 0 00", n_ack, n_val, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_pend_drop;
    int n_we = 0;
    int n_ack = 0;
    int ack_k = -1;
    mem[13'h0ABC] <= 8'h11;
    idle_inputs();
    tick();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h0ABC;
    cpu_wdata = 8'hFF;
    vid_req   = 1'b1;
    tick();
    tick();
    cpu_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ram_we === 1'b1) n_we++;
      if (cpu_ack === 1'b1) n_ack++;
    end
    vid_req = 1'b0;
    #1;
    n_total++;
    if (n_we != 0 || n_ack != 0 || mem[13'h0ABC] !== 8'h11)
      $display("FAIL drop_no_access: writes %0d acks %0d ram %h want 0 0 11", n_we, n_ack, mem[13'h0ABC]);
    else n_pass++;
    n_total++;
    if (cpu_wait_n !== 1'b1) $display("FAIL drop_wait: got %b want 1", cpu_wait_n);
    else n_pass++;
    tick();
    // A fresh request must see the full IDLE->PEND step again
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cpu_ack === 1'b1 && ack_k < 0) ack_k = k;
    end
    n_total++;
    if (ack_k != 4 || cpu_rdata !== 8'h11)
      $display("FAIL drop_idle_restart: ack tick %0d rdata %h want 4 11", ack_k, cpu_rdata);
    else n_pass++;
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_vid_burst();
    test_starve();
    test_held_req();
    test_reset_mid();
    test_pend_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
